// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, data-bus handshake, writeback and fault signals of the memory stage.
// bus_err exists only when MEM_STAGE_BUS_ERR_EN is defined.
interface mem_stage_if #(parameter int WordSize = 32);
  logic                ex_valid;
  logic                ex_load;
  logic                ex_store;
  logic [4:0]          ex_rdn;
  logic [WordSize-1:0] ex_alu_out;
  logic [WordSize-1:0] ex_mem_data;
  logic                stall;
  logic                bus_req;
  logic                bus_we;
  logic [WordSize-1:0] bus_addr;
  logic [WordSize-1:0] bus_wdata;
  logic                bus_ack;
  logic [WordSize-1:0] bus_rdata;
`ifdef MEM_STAGE_BUS_ERR_EN
  logic                bus_err;
`endif
  logic                wb_valid;
  logic [4:0]          wb_rdn;
  logic [WordSize-1:0] wb_data;
  logic                fault;
  logic                fault_clr;

  modport master (
    input  ex_valid, ex_load, ex_store, ex_rdn, ex_alu_out, ex_mem_data,
    input  bus_ack, bus_rdata, fault_clr,
`ifdef MEM_STAGE_BUS_ERR_EN
    input  bus_err,
`endif
    output stall, bus_req, bus_we, bus_addr, bus_wdata,
    output wb_valid, wb_rdn, wb_data, fault
  );

  modport slave (
    output ex_valid, ex_load, ex_store, ex_rdn, ex_alu_out, ex_mem_data,
    output bus_ack, bus_rdata, fault_clr,
`ifdef MEM_STAGE_BUS_ERR_EN
    output bus_err,
`endif
    input  stall, bus_req, bus_we, bus_addr, bus_wdata,
    input  wb_valid, wb_rdn, wb_data, fault
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences the EX/MEM memory op onto a single-outstanding req/ack bus, stalls upstream, times out into a sticky fault.
// Optional MEM_STAGE_BUS_ERR_EN: bus_ack with bus_err faults instead of completing.
module mem_stage_ctrl #(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 16
) (
  input logic          clk,
  input logic          rst,
  mem_stage_if.master  m
);
  localparam int CW = $clog2(TimeoutCycles) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                load_q;
  logic [4:0]          rdn_q;
  logic                bus_we_q;
  logic [WordSize-1:0] bus_addr_q;
  logic [WordSize-1:0] bus_wdata_q;
  logic                wb_valid_q;
  logic [4:0]          wb_rdn_q;
  logic [WordSize-1:0] wb_data_q;
  logic                mem_op;
  logic                err_ack;
  logic                ok_ack;
  logic                tmo;

  assign mem_op = m.ex_valid & (m.ex_load | m.ex_store);
`ifdef MEM_STAGE_BUS_ERR_EN
  assign err_ack = m.bus_ack & m.bus_err;
`else
  assign err_ack = 1'b0;
`endif
  assign ok_ack = m.bus_ack & ~err_ack;
  assign tmo    = cnt_q == CW'(TimeoutCycles - 1);

  // bus_req and fault decode straight from the state register so they never glitch
  assign m.bus_req   = state_q == BUSY;
  assign m.fault     = state_q == FAULT;
  assign m.bus_we    = bus_we_q;
  assign m.bus_addr  = bus_addr_q;
  assign m.bus_wdata = bus_wdata_q;
  assign m.wb_valid  = wb_valid_q;
  assign m.wb_rdn    = wb_rdn_q;
  assign m.wb_data   = wb_data_q;

  always_comb
    m.stall = state_q == IDLE ? mem_op :
              state_q == BUSY ? ~ok_ack : ~m.fault_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      rdn_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rdn_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (mem_op) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            bus_addr_q  <= m.ex_alu_out;
            bus_wdata_q <= m.ex_mem_data;
            bus_we_q    <= ~m.ex_load;
            load_q      <= m.ex_load;
            rdn_q       <= m.ex_rdn;
          end else if (m.ex_valid) begin
            wb_valid_q <= 1'b1;
            wb_rdn_q   <= m.ex_rdn;
            wb_data_q  <= m.ex_alu_out;
          end
        BUSY:
          if (ok_ack) begin
            state_q    <= IDLE;
            wb_valid_q <= load_q;
            if (load_q) begin
              wb_rdn_q  <= rdn_q;
              wb_data_q <= m.bus_rdata;
            end
          end else if (err_ack || tmo) begin
            state_q <= FAULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        FAULT:
          if (m.fault_clr) state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end
endmodule
